instruction_sequencer: RTL and testbench

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

---
 rtl/instruction_sequencer.sv | 127 ++++++++++++
 tb/tb_instruction_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - fetch/decode/indirect/execute sequencer with PC, AR, IR and timing counter
module instruction_sequencer #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 16,
    parameter int PC_RESET = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [2:0]        opcode,
    input  logic [7:0]        decoded_signal,
    output logic              ind,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] ar,
    output logic [3:0]        sc,
    output logic              exec_en,
    input  logic              sc_clr,
    output logic              seq_err
);

    typedef enum logic [2:0] {
        S_T0,
        S_FETCH,
        S_DECODE,
        S_INDIR,
        S_EXEC
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc_next, ar_next;
    logic [DATA_W-1:0] ir_next;
    logic              ind_next;
    logic [3:0]        sc_next;
    logic              err_next;

    // Only the register-reference line of the decoder steers the sequence.
    logic unused_decode;
    assign unused_decode = ^decoded_signal[6:0];

    assign mem_addr = ar;
    assign opcode   = ir[DATA_W-2:DATA_W-4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_T0;
            pc      <= ADDR_W'(PC_RESET);
            ar      <= '0;
            ir      <= '0;
            ind     <= 1'b0;
            sc      <= 4'd0;
            seq_err <= 1'b0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            ar      <= ar_next;
            ir      <= ir_next;
            ind     <= ind_next;
            sc      <= sc_next;
            seq_err <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        ar_next    = ar;
        ir_next    = ir;
        ind_next   = ind;
        sc_next    = sc;
        err_next   = 1'b0;
        mem_req    = 1'b0;
        exec_en    = 1'b0;
        case (state)
            S_T0: begin
                ar_next    = pc;
                sc_next    = 4'd1;
                state_next = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_next    = mem_rdata;
                    pc_next    = pc + ADDR_W'(1);
                    sc_next    = 4'd2;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                ar_next  = ir[ADDR_W-1:0];
                ind_next = ir[DATA_W-1];
                sc_next  = 4'd3;
                // Register-reference instructions reuse the I bit, so no pointer fetch for them.
                if (ir[DATA_W-1] && !decoded_signal[7])
                    state_next = S_INDIR;
                else
                    state_next = S_EXEC;
            end
            S_INDIR: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ar_next    = mem_rdata[ADDR_W-1:0];
                    sc_next    = 4'd4;
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                exec_en = 1'b1;
                if (sc_clr) begin
                    sc_next    = 4'd0;
                    state_next = S_T0;
                end else if (sc == 4'hF) begin
                    sc_next    = 4'd0;
                    err_next   = 1'b1;
                    state_next = S_T0;
                end else begin
                    sc_next = sc + 4'd1;
                end
            end
            default: state_next = S_T0;
        endcase
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - table-driven scoreboard bench for instruction_sequencer
module tb_instruction_sequencer;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [2:0]  opcode;
    logic [7:0]  decoded_signal;
    logic        ind;
    logic [15:0] ir;
    logic [11:0] pc;
    logic [11:0] ar;
    logic [3:0]  sc;
    logic        exec_en;
    logic        sc_clr;
    logic        seq_err;

    instruction_sequencer #(.ADDR_W(12), .DATA_W(16), .PC_RESET(0)) dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .opcode(opcode),
        .decoded_signal(decoded_signal), .ind(ind), .ir(ir), .pc(pc), .ar(ar),
        .sc(sc), .exec_en(exec_en), .sc_clr(sc_clr), .seq_err(seq_err)
    );

    // One-hot opcode decoder model.
    assign decoded_signal = 8'b1 << opcode;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] word;
        logic [15:0] iword;
        int          fwait;
        int          iwait;
        int          exec_len;
        bit          spur;
        logic [2:0]  exp_op;
        logic        exp_ind;
        logic [11:0] exp_ar;
        logic [3:0]  exp_sc;
    } vec_t;

    typedef struct {
        logic [15:0] ir;
        logic [11:0] pc;
        logic [11:0] ar;
        logic [3:0]  sc;
        logic        ind;
        logic [2:0]  op;
    } exp_t;

    int          total = 0;
    int          bad   = 0;
    logic [11:0] exp_pc;
    exp_t        sb[$];
    vec_t        vecs[7];
    vec_t        filler;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_pc"}, 32'(pc), 32'h0);
        chk({tag, "_ar"}, 32'(ar), 32'h0);
        chk({tag, "_ir"}, 32'(ir), 32'h0);
        chk({tag, "_ind"}, 32'(ind), 32'h0);
        chk({tag, "_sc"}, 32'(sc), 32'h0);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'h0);
        chk({tag, "_exec_en"}, 32'(exec_en), 32'h0);
        chk({tag, "_seq_err"}, 32'(seq_err), 32'h0);
    endtask

    // Entered at a falling edge; leaves at the falling edge where the DUT is back in T0.
    task automatic run_instr(input vec_t v);
        int   fcnt;
        int   icnt;
        int   nexec;
        bit   got_exec;
        bit   tmo;
        exp_t e;
        exp_t g;
        fcnt     = 0;
        icnt     = 0;
        got_exec = 0;
        tmo      = (int'(v.exp_sc) + v.exec_len > 15);
        for (int cyc = 0; cyc < 64 && !got_exec; cyc++) begin
            if (cyc > 0) @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = 16'hDEAD;
            sc_clr    = v.spur;
            if (exec_en) begin
                got_exec = 1;
            end else if (mem_req && sc == 4'd1) begin
                chk("fetch_addr", 32'(mem_addr), 32'(exp_pc));
                chk("seq_err_low", 32'(seq_err), 32'h0);
                if (fcnt == v.fwait) begin
                    mem_ack   = 1'b1;
                    mem_rdata = v.word;
                    e.ir  = v.word;
                    e.pc  = exp_pc + 12'd1;
                    e.ar  = v.exp_ar;
                    e.sc  = v.exp_sc;
                    e.ind = v.exp_ind;
                    e.op  = v.exp_op;
                    sb.push_back(e);
                    exp_pc = exp_pc + 12'd1;
                end
                fcnt++;
            end else if (mem_req && sc == 4'd3) begin
                chk("indir_addr", 32'(mem_addr), 32'(v.word[11:0]));
                if (icnt == v.iwait) begin
                    mem_ack   = 1'b1;
                    mem_rdata = v.iword;
                end
                icnt++;
            end else if (v.spur) begin
                mem_ack   = 1'b1;
                mem_rdata = 16'hBEEF;
            end
        end
        chk("exec_reached", 32'(got_exec), 32'h1);
        if (!got_exec) return;
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 32'h0, 32'h1);
        end else begin
            g = sb.pop_front();
            chk("ir", 32'(ir), 32'(g.ir));
            chk("pc", 32'(pc), 32'(g.pc));
            chk("ar", 32'(ar), 32'(g.ar));
            chk("sc_exec_entry", 32'(sc), 32'(g.sc));
            chk("ind", 32'(ind), 32'(g.ind));
            chk("opcode", 32'(opcode), 32'(g.op));
        end
        chk("fetch_cycles", 32'(fcnt), 32'(v.fwait + 1));
        nexec = 0;
        for (int c = 0; c < 20; c++) begin
            if (!exec_en) break;
            chk("exec_sc", 32'(sc), 32'(v.exp_sc) + 32'(c));
            mem_ack = v.spur;
            sc_clr  = (c == v.exec_len);
            nexec++;
            @(negedge clk);
        end
        sc_clr  = 1'b0;
        mem_ack = 1'b0;
        chk("exec_cycles", 32'(nexec), tmo ? 32'(16 - int'(v.exp_sc)) : 32'(v.exec_len + 1));
        chk("t0_exec_en", 32'(exec_en), 32'h0);
        chk("t0_sc", 32'(sc), 32'h0);
        chk("t0_mem_req", 32'(mem_req), 32'h0);
        chk("t0_seq_err", 32'(seq_err), 32'(tmo));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        //            word      iword     fw iw exec spur op    ind   ar       sc
        vecs[0] = '{16'h2123, 16'h0000, 0, 0, 2,  1'b0, 3'd2, 1'b0, 12'h123, 4'd3};
        vecs[1] = '{16'h2123, 16'h0000, 3, 0, 0,  1'b0, 3'd2, 1'b0, 12'h123, 4'd3};
        vecs[2] = '{16'h9040, 16'h0ABC, 0, 0, 1,  1'b0, 3'd1, 1'b1, 12'hABC, 4'd4};
        vecs[3] = '{16'hF800, 16'h0000, 0, 0, 0,  1'b1, 3'd7, 1'b1, 12'h800, 4'd3};
        vecs[4] = '{16'hC555, 16'hF321, 1, 2, 11, 1'b1, 3'd4, 1'b1, 12'h321, 4'd4};
        vecs[5] = '{16'h7FFF, 16'h0000, 0, 0, 99, 1'b0, 3'd7, 1'b0, 12'hFFF, 4'd3};
        vecs[6] = '{16'h0000, 16'h0000, 1, 0, 0,  1'b0, 3'd0, 1'b0, 12'h000, 4'd3};
        filler  = '{16'hF800, 16'h0000, 0, 0, 0,  1'b0, 3'd7, 1'b1, 12'h800, 4'd3};

        rst_n     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        sc_clr    = 1'b0;
        exp_pc    = 12'h000;
        @(negedge clk);
        @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) run_instr(filler);
        for (int i = 0; i < 7; i++) run_instr(vecs[i]);

        // Asynchronous reset in the middle of a wait-stated fetch, with ack asserted throughout.
        @(negedge clk);
        chk("pre_reset_fetch", 32'(mem_req), 32'h1);
        #2;
        rst_n     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 16'hFFFF;
        #1;
        check_reset("async");
        @(negedge clk);
        check_reset("held");
        rst_n = 1'b1;
        chk("release_t0_mem_req", 32'(mem_req), 32'h0);
        @(negedge clk);
        chk("post_release_mem_req", 32'(mem_req), 32'h1);
        chk("post_release_addr", 32'(mem_addr), 32'h000);
        chk("post_release_sc", 32'(sc), 32'h1);
        chk("post_release_ir", 32'(ir), 32'h0);
        exp_pc = 12'h000;
        sb.delete();
        run_instr(vecs[0]);

        while (exp_pc != 12'hFFF) run_instr(filler);
        run_instr(filler);
        chk("pc_wrap", 32'(pc), 32'h000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
